// File: rtl/riscv_lsu.sv
// riscv_lsu -- load/store unit in front of the data RAM wrapper.
//
// Takes one request at a time from the MEM stage and issues word-aligned
// accesses to a synchronous RAM. Sub-word stores are done as
// read-modify-write, so every RAM write is a full word. Load data is
// lane-extracted and sign/zero-extended. Misaligned requests get an error
// response and never touch memory.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_we, req_size      store flag, size (00 B, 01 H, 10 W, 11 reserved)
//   req_unsigned          zero-extend sub-word loads
//   req_addr, req_wdata   byte address, right-justified store data
//   resp_valid            one-cycle completion pulse
//   resp_rdata, resp_err  load result (0 for stores/errors), error flag
//   mem_addr              registered word address to the RAM
//   mem_write_en          full-word write strobe
//   mem_wdata, mem_rdata  RAM write / read data
module riscv_lsu #(
  parameter int MEM_RD_LAT = 1,
  parameter int CNT_W      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_write_en,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             we_q, uns_q, err_q;
  logic [1:0]       size_q, lane_q;
  logic [15:0]      wdata_q;     // only sub-word stores need the latched data
  logic             accept, misaligned, rd_done;
  logic [31:0]      shifted, extracted, merged;

  assign accept     = req_valid && (state == IDLE);
  assign misaligned = (req_size == 2'b11) ||
                      (req_size == 2'b01 && req_addr[0]) ||
                      (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  // RAM data is valid in the last RD cycle (counter reached the latency)
  assign rd_done    = (state == RD) && (cnt == CNT_W'(MEM_RD_LAT));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) begin
        if (misaligned)                       state_nxt = RESP;
        else if (req_we && req_size == 2'b10) state_nxt = WR;
        else                                  state_nxt = RD;
      end
      RD:   if (rd_done) state_nxt = we_q ? WR : RESP;
      WR:   state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the state register, so they are glitch-free
  always_comb begin
    req_ready    = (state == IDLE);
    resp_valid   = (state == RESP);
    resp_err     = (state == RESP) && err_q;
    mem_write_en = (state == WR);
  end

  // Lane extraction: shift the addressed lane down, then extend
  always_comb begin
    shifted   = mem_rdata >> {lane_q, 3'b000};
    extracted = mem_rdata;
    case (size_q)
      2'b00:   extracted = uns_q ? {24'h0, shifted[7:0]}
                                 : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   extracted = uns_q ? {16'h0, shifted[15:0]}
                                 : {{16{shifted[15]}}, shifted[15:0]};
      default: extracted = mem_rdata;
    endcase
  end

  // Read-modify-write merge for SB/SH
  always_comb begin
    merged = mem_rdata;
    if (size_q == 2'b00) begin
      case (lane_q)
        2'd0: merged[7:0]   = wdata_q[7:0];
        2'd1: merged[15:8]  = wdata_q[7:0];
        2'd2: merged[23:16] = wdata_q[7:0];
        2'd3: merged[31:24] = wdata_q[7:0];
        default: merged = mem_rdata;
      endcase
    end else if (lane_q[1]) begin
      merged[31:16] = wdata_q;
    end else begin
      merged[15:0]  = wdata_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= 2'b00;
      lane_q     <= 2'b00;
      wdata_q    <= 16'h0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      resp_rdata <= 32'h0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        err_q   <= misaligned;
        size_q  <= req_size;
        lane_q  <= req_addr[1:0];
        wdata_q <= req_wdata[15:0];
        cnt     <= '0;
        if (misaligned) resp_rdata <= 32'h0;
        else            mem_addr   <= {req_addr[31:2], 2'b00};
        if (!misaligned && req_we && req_size == 2'b10) mem_wdata <= req_wdata;
      end
      if (state == RD) begin
        cnt <= rd_done ? '0 : cnt + 1'b1;
        if (rd_done) begin
          if (we_q) mem_wdata  <= merged;
          else      resp_rdata <= extracted;
        end
      end
      // stores report zero data
      if (state == WR) resp_rdata <= 32'h0;
    end
  end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
Load/store unit sitting directly upstream of the data RAM wrapper (riscv_cache_d). It accepts one memory request at a time from the MEM pipeline stage and issues word-aligned accesses to the RAM. Sub-word stores are done as read-modify-write, so every RAM write is a full word. Load data is returned lane-extracted and sign- or zero-extended, with a one-cycle response pulse. Misaligned requests are rejected without touching memory.

Parameters:
MEM_RD_LAT, 1, cycles from mem_addr valid to mem_rdata valid (synchronous RAM read latency, >=1)
CNT_W, 2, width of the read-latency counter; must hold MEM_RD_LAT

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (high only in IDLE)
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as misaligned)
req_unsigned  input  1  loads: 1 zero-extend, 0 sign-extend
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  load result; 0 for stores and errors
resp_err  output  1  qualifies resp_valid: misaligned or reserved size
mem_addr  output  32  {addr[31:2],2'b00}, registered
mem_write_en  output  1  RAM write strobe, only ever asserted for full-word writes
mem_wdata  output  32  full word to write
mem_rdata  input  32  RAM read data

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_err 0, resp_rdata 0, mem_write_en 0, mem_addr 0, mem_wdata 0, latency counter 0.
- Handshake: a request is accepted on a rising edge where req_valid and req_ready are both 1. On acceptance, addr, size, we, unsigned and wdata are latched. Inputs are ignored at all other times.
- Misalignment check at acceptance: half with addr[0]=1, word with addr[1:0]!=0, or size=11 goes to RESP with resp_err=1 and no memory access.
- States:
  - IDLE: req_ready=1.
    - Aligned load or SB/SH goes to RD.
    - Aligned SW goes to WR.
    - Error goes to RESP.
  - RD: mem_addr is held. The counter runs from 0 to MEM_RD_LAT, so RD lasts MEM_RD_LAT+1 cycles. In the cycle where count==MEM_RD_LAT, mem_rdata is sampled.
    - Load: the extracted value is latched into resp_rdata; next state is RESP.
    - SB/SH: the merged word is latched into mem_wdata; next state is WR.
  - WR: mem_write_en=1 for exactly one cycle with the latched mem_addr and mem_wdata; next state is RESP.
  - RESP: resp_valid=1 for one cycle, req_ready=0; next state is IDLE.
- Merge rules:
  - SB replaces byte lane addr[1:0] with wdata[7:0].
  - SH replaces half addr[1] with wdata[15:0].
  - SW writes wdata unchanged.
- Extract rules:
  - Byte lane addr[1:0], half addr[1], or full word.
  - Extended per req_unsigned. Word loads ignore req_unsigned.
- Latency, counted as cycles after the accepting edge before the resp_valid cycle:
  - load: MEM_RD_LAT+1
  - SW: 1
  - SB/SH: MEM_RD_LAT+2
  - error: 0 (resp_valid high in the first cycle after acceptance)
- Back-to-back: a new request can be accepted at the earliest in the cycle after RESP. There is no overlap and no write-to-read forwarding is needed, because each access completes before the next is accepted.
- Reset mid-operation: rst overrides everything.
  - The next state is IDLE and all outputs return to reset values after the edge.
  - A WR cycle coincident with rst still drives mem_write_en in that cycle, since outputs are registered. A write in flight after the reset edge never happens.
  - req_valid in a reset cycle is not accepted.
- resp_rdata holds its value until the next RESP or reset.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> req_ready=1, resp_valid=0, mem_write_en=0, all outputs 0.
- SW addr 0x100, data 0xDEADBEEF -> one cycle with mem_write_en=1, mem_addr=0x100, mem_wdata=0xDEADBEEF. resp_valid one cycle later, resp_err=0. No RD cycle occurs.
- Memory word at 0x100 = 0xDEADBEEF; SB addr 0x102, wdata 0x55 -> RD then WR with mem_wdata=0xDE55BEEF. Subsequent LW 0x100 returns 0xDE55BEEF after MEM_RD_LAT+1 cycles.
- Word 0x80F0_7F01 at 0x200:
  - LB 0x203 -> 0xFFFFFF80
  - LBU 0x203 -> 0x00000080
  - LH 0x200 -> 0x00007F01
  - LHU 0x202 -> 0x000080F0
- Misaligned: LH 0x101, SW 0x102, size=11 -> resp_valid with resp_err=1 one cycle after accept, resp_rdata=0, mem_write_en never asserted.
- Reset mid-operation: assert rst during RD of an SB -> next cycle IDLE, no write issued, RAM unchanged. A following LW returns the original word.
